// File: rtl/md_sched.sv
// Multiply/divide scheduler: holds HI/LO and sequences MULT/DIV results through a
// fixed-latency busy window, requesting a pipeline stall while a D-stage md instruction must wait.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] phi, plo;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        divisor, abs_a, abs_b;
  logic [31:0]        uq, ur, sq_mag, sr_mag, sq, sr;
  logic [31:0]        res_hi, res_lo;
  logic               div_zero;

  assign prod_s = $signed(a) * $signed(b);
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divisor forced non-zero so the dividers never see 0; the b==0 result is discarded below.
  assign div_zero = (b == 32'd0);
  assign divisor  = div_zero ? 32'd1 : b;
  assign abs_a    = a[31] ? (32'd0 - a) : a;
  assign abs_b    = divisor[31] ? (32'd0 - divisor) : divisor;
  assign uq       = a / divisor;
  assign ur       = a % divisor;
  assign sq_mag   = abs_a / abs_b;
  assign sr_mag   = abs_a % abs_b;
  assign sq       = (a[31] ^ divisor[31]) ? (32'd0 - sq_mag) : sq_mag;
  assign sr       = a[31] ? (32'd0 - sr_mag) : sr_mag;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (op)
      3'd0: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      3'd1: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      3'd2: if (!div_zero) begin res_hi = sr; res_lo = sq; end
      3'd3: if (!div_zero) begin res_hi = ur; res_lo = uq; end
      default: ;
    endcase
  end

  assign stall = d_md_use & (busy | (start & ~op[2]));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      phi   <= 32'd0;
      plo   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                phi   <= res_hi;
                plo   <= res_lo;
                cnt   <= op[1] ? DIV_LOAD : MULT_LOAD;
                state <= BUSY;
                busy  <= 1'b1;
              end
              3'd4: hi <= a;
              3'd5: lo <= a;
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            hi    <= phi;
            lo    <= plo;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: a cycle-counting reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_md_sched;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        d_md_use;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .d_md_use(d_md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (act=timeout req=finish)");
    $fatal(1, "watchdog");
  end

  // reference model: an accepted op completes at the edge N edges after acceptance
  int          edge_no = 0;
  int          done_at = -1;
  logic [31:0] hi_m = '0, lo_m = '0, ph_m = '0, pl_m = '0;

  always @(posedge clk) begin
    longint          sa, sb, q, r;
    longint unsigned ua, ub, pu;
    edge_no++;
    if (!reset) begin
      hi_m = '0; lo_m = '0; done_at = -1;
    end else if (done_at >= 0) begin
      if (edge_no == done_at) begin
        hi_m = ph_m; lo_m = pl_m; done_at = -1;
      end
    end else if (start) begin
      sa = $signed(a); sb = $signed(b);
      ua = {32'd0, a}; ub = {32'd0, b};
      case (op)
        3'd0: begin q = sa * sb; {ph_m, pl_m} = q[63:0]; done_at = edge_no + MC; end
        3'd1: begin pu = ua * ub; {ph_m, pl_m} = pu[63:0]; done_at = edge_no + MC; end
        3'd2: begin
          if (b == 0) begin ph_m = hi_m; pl_m = lo_m; end
          else begin q = sa / sb; r = sa % sb; ph_m = r[31:0]; pl_m = q[31:0]; end
          done_at = edge_no + DC;
        end
        3'd3: begin
          if (b == 0) begin ph_m = hi_m; pl_m = lo_m; end
          else begin pu = ua / ub; ph_m = 32'(ua % ub); pl_m = pu[31:0]; end
          done_at = edge_no + DC;
        end
        3'd4: hi_m = a;
        3'd5: lo_m = a;
        default: ;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: act=%h req=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle scoreboard against the model
  always @(negedge clk) begin
    logic exp_busy, exp_stall;
    if (chk_en) begin
      exp_busy  = (done_at >= 0);
      exp_stall = d_md_use & (exp_busy | (start & (op <= 3'd3)));
      chk("cyc_busy", 32'(busy), 32'(exp_busy));
      chk("cyc_stall", 32'(stall), 32'(exp_stall));
      chk("cyc_hi", hi, hi_m);
      chk("cyc_lo", lo, lo_m);
    end
  end

  // driver: called #1 after a posedge; issues one op and waits for busy to drop
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int n, input logic [31:0] h0, input logic [31:0] l0,
                        input logic [31:0] eh, input logic [31:0] el, input string nm);
    int cnt;
    start = 1'b1; op = o; a = x; b = y;
    #1;
    if (d_md_use) chk({nm, "_stall_start"}, 32'(stall), 32'd1);
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      if (d_md_use) chk({nm, "_stall_busy"}, 32'(stall), 32'd1);
      chk({nm, "_hi_hold"}, hi, h0);
      chk({nm, "_lo_hold"}, lo, l0);
      @(posedge clk); #1;
    end
    chk({nm, "_busy_len"}, 32'(cnt), 32'(n));
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    if (d_md_use) chk({nm, "_stall_after"}, 32'(stall), 32'd0);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; d_md_use = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    step(1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    step(1);

    // MULT with a D-stage md instruction held waiting
    d_md_use = 1'b1;
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, MC, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
    d_md_use = 1'b0;

    // MULTU then DIVU back-to-back in the first idle cycle
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
           32'hFFFF_FFFE, 32'h0000_0001, "multu");
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFE, 32'h0000_0001,
           32'h0000_0001, 32'h7FFF_FFFC, "divu");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, DC, 32'h0000_0001, 32'h7FFF_FFFC,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           32'h0000_0000, 32'h8000_0000, "div_ovf");

    // MTHI / MTLO one-cycle writes, then divide by zero keeps them
    start = 1'b1; op = 3'd4; a = 32'h1234;
    step(1);
    chk("mthi_busy", 32'(busy), 32'd0);
    chk("mthi_hi", hi, 32'h1234);
    op = 3'd5; a = 32'h5678;
    step(1);
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h5678);
    run_op(3'd2, 32'd9, 32'd0, DC, 32'h1234, 32'h5678, 32'h1234, 32'h5678, "div0");

    // reserved op codes
    start = 1'b1; op = 3'd6; a = 32'hAAAA_AAAA;
    step(1);
    op = 3'd7;
    step(1);
    start = 1'b0;
    chk("rsv_busy", 32'(busy), 32'd0);
    chk("rsv_hi", hi, 32'h1234);
    chk("rsv_lo", lo, 32'h5678);

    // MTHI while busy is ignored
    start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
    step(1);
    start = 1'b0;
    step(2);
    start = 1'b1; op = 3'd4; a = 32'hDEAD;
    step(1);
    start = 1'b0;
    chk("ign_hi_mid", hi, 32'h1234);
    step(5);
    chk("ign_busy", 32'(busy), 32'd0);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd6);

    // reset during the 4th busy cycle of a DIV
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    step(1);
    start = 1'b0;
    step(3);
    chk("rmid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_hi", hi, 32'd0);
    chk("rmid_lo", lo, 32'd0);
    step(14);
    chk("rmid_hi_late", hi, 32'd0);
    chk("rmid_lo_late", lo, 32'd0);

    // stall is purely combinational on inputs while idle
    d_md_use = 1'b1; start = 1'b1; op = 3'd4;
    #1;
    chk("stall_mthi", 32'(stall), 32'd0);
    start = 1'b0; d_md_use = 1'b0;
    step(1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
